// File: rtl/mem_rd_arbiter.sv
// Round-robin arbiter sharing one memory read port between fetch and load; one read in flight.
// Grant lands one cycle after request; response one cycle after MRVld or watchdog expiry; requesters hold Rdy until Vld.
module mem_rd_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          IRRdy,
    input  logic [AW-1:0] IRAddr,
    output logic          IRVld,
    output logic [DW-1:0] IRData,
    input  logic          DRRdy,
    input  logic [AW-1:0] DRAddr,
    output logic          DRVld,
    output logic [DW-1:0] DRData,
    output logic          MRRdy,
    output logic [AW-1:0] MRAddr,
    input  logic          MRVld,
    input  logic [DW-1:0] MRData,
    output logic          Err,
    output logic          Busy
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    state_t        state_q, state_d;
    logic          owner_q, owner_d;     // 0 = fetch, 1 = load
    logic          last_q, last_d;
    logic [15:0]   cnt_q, cnt_d;
    logic          mrrdy_q, mrrdy_d;
    logic [AW-1:0] mraddr_q, mraddr_d;
    logic          irvld_q, irvld_d;
    logic [DW-1:0] irdata_q, irdata_d;
    logic          drvld_q, drvld_d;
    logic [DW-1:0] drdata_q, drdata_d;
    logic          err_q, err_d;
    logic          busy_q, busy_d;

    logic req_any, req_both, grant, timeout_hit;

    assign req_any     = IRRdy | DRRdy;
    assign req_both    = IRRdy & DRRdy;
    // On a tie the side that was not granted last wins; otherwise whoever asks.
    assign grant       = req_both ? ~last_q : DRRdy;
    assign timeout_hit = (cnt_q == TO_LAST);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (req_any) state_d = S_WAIT;
            S_WAIT:  if (MRVld || timeout_hit) state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        owner_d  = owner_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        mrrdy_d  = mrrdy_q;
        mraddr_d = mraddr_q;
        irvld_d  = 1'b0;
        irdata_d = irdata_q;
        drvld_d  = 1'b0;
        drdata_d = drdata_q;
        err_d    = 1'b0;
        busy_d   = (state_d != S_IDLE);
        case (state_q)
            S_IDLE: begin
                if (req_any) begin
                    owner_d  = grant;
                    mraddr_d = grant ? DRAddr : IRAddr;
                    mrrdy_d  = 1'b1;
                    cnt_d    = 16'd0;
                    if (req_both) last_d = grant;
                end
            end
            S_WAIT: begin
                // A real response on the expiry edge takes precedence over the error.
                if (MRVld) begin
                    mrrdy_d = 1'b0;
                    if (owner_q) begin
                        drvld_d  = 1'b1;
                        drdata_d = MRData;
                    end else begin
                        irvld_d  = 1'b1;
                        irdata_d = MRData;
                    end
                end else if (timeout_hit) begin
                    mrrdy_d = 1'b0;
                    err_d   = 1'b1;
                    if (owner_q) begin
                        drvld_d  = 1'b1;
                        drdata_d = '0;
                    end else begin
                        irvld_d  = 1'b1;
                        irdata_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
            cnt_q    <= '0;
            mrrdy_q  <= 1'b0;
            mraddr_q <= '0;
            irvld_q  <= 1'b0;
            irdata_q <= '0;
            drvld_q  <= 1'b0;
            drdata_q <= '0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            owner_q  <= owner_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            mrrdy_q  <= mrrdy_d;
            mraddr_q <= mraddr_d;
            irvld_q  <= irvld_d;
            irdata_q <= irdata_d;
            drvld_q  <= drvld_d;
            drdata_q <= drdata_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
        end
    end

    assign MRRdy  = mrrdy_q;
    assign MRAddr = mraddr_q;
    assign IRVld  = irvld_q;
    assign IRData = irdata_q;
    assign DRVld  = drvld_q;
    assign DRData = drdata_q;
    assign Err    = err_q;
    assign Busy   = busy_q;

endmodule

// File: doc/mem_rd_arbiter.md
# mem_rd_arbiter

Two-requester read-port arbiter for the lanzones core. It shares one memory read port between the instruction-fetch side and the data-load side. It uses the same RRdy/RAddr/RVld/RData request/response convention on every port. Exactly one transaction is outstanding at a time. Simultaneous requests are resolved round-robin, and a watchdog terminates reads the memory never answers.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width
- TIMEOUT, 255, maximum WAIT cycles before an error response; legal range 1..65535

Ports:
- clk  in  1  single clock; all state changes on posedge
- rstn  in  1  reset, asynchronous and active-low
- IRRdy  in  1  fetch request; held high with IRAddr stable until IRVld
- IRAddr  in  AW  fetch address
- IRVld  out  1  fetch response, one-cycle pulse
- IRData  out  DW  fetch data, valid while IRVld=1
- DRRdy  in  1  load request; same rules as IRRdy
- DRAddr  in  AW  load address
- DRVld  out  1  load response, one-cycle pulse
- DRData  out  DW  load data, valid while DRVld=1
- MRRdy  out  1  request to memory
- MRAddr  out  AW  address to memory
- MRVld  in  1  memory response valid
- MRData  in  DW  memory response data
- Err  out  1  pulses together with IRVld or DRVld when a read timed out
- Busy  out  1  high when the state is not IDLE

## Operation
- State machine: IDLE, WAIT, RESP. All outputs are registered.
- Reset state: IDLE. Every output is 0, including MRAddr and both data buses. Owner=I, last-grant=D, timeout counter=0.
- IDLE, no request: stay in IDLE.
- IDLE, one requester high: grant it. Set owner, MRAddr<=owner address, MRRdy<=1, counter<=0, go to WAIT.
- IDLE, both requesters high: grant the side that is not last-grant, then update last-grant. The first tie after reset goes to fetch.
- WAIT, MRVld=1:
  - MRRdy<=0.
  - Owner Vld<=1, owner Data<=MRData.
  - The non-owner Vld and Data are unchanged (0).
  - Go to RESP.
- WAIT, MRVld=0:
  - Increment the counter.
  - If counter==TIMEOUT-1: MRRdy<=0, owner Vld<=1, owner Data<=0, Err<=1, go to RESP.
- RESP:
  - Clear IRVld, DRVld and Err. Data buses hold their last value.
  - Requests are ignored; go to IDLE.
  - A requester still high in the next IDLE cycle is treated as a new request.
- MRVld arriving in IDLE or RESP is ignored. No output changes and no state change.
- MRAddr holds the last issued address after the transaction completes.
- The arbiter samples the address only at grant. A requester that changes its address mid-transaction does not affect MRAddr.
- A requester that drops its Rdy before its Vld has no effect on the sequence. The response is still delivered to it.
- Counter width is 16 bits.

## Timing
- Request high at edge N (state IDLE) -> MRRdy=1 and MRAddr valid after edge N.
- MRVld=1 sampled at edge M -> XRVld=1 after edge M for exactly one cycle -> IDLE after edge M+1.
- Minimum issue-to-issue spacing is 3 cycles: IDLE -> WAIT -> RESP -> IDLE with zero memory latency.
  - Zero latency means MRVld is high at the first WAIT edge.
- Timeout: MRRdy is high for exactly TIMEOUT cycles. Err and Vld assert after the TIMEOUT-th WAIT edge.
- MRVld on the same edge as the timeout compare: the valid response wins, so Err=0 and Data=MRData.
- Reset asserted mid-WAIT or mid-RESP:
  - All outputs go to 0 immediately (asynchronous).
  - The transaction is lost; no response is delivered after release.
  - Arbitration restarts with fetch priority.

## Test plan
- Single fetch: IRRdy=1, IRAddr=0x100. Memory answers MRVld with 0x00000013 two cycles after MRRdy rises.
  - Required: MRAddr=0x100.
  - Required: IRVld pulses one cycle with IRData=0x13.
  - Required: DRVld stays 0 and Busy falls one cycle later.
- Simultaneous requests just after reset: IRAddr=0x200, DRAddr=0x8000 held high, zero-latency memory.
  - Required: grants alternate fetch, load, fetch, load.
  - Required: MRAddr sequence 0x200, 0x8000, 0x200, 0x8000, issued 3 cycles apart.
- Timeout: TIMEOUT=4, DRRdy=1, MRVld never asserted.
  - Required: MRRdy high exactly 4 cycles.
  - Required: then DRVld=1, Err=1, DRData=0 for one cycle.
  - Required: back to IDLE.
- Response on the timeout edge: TIMEOUT=4 and MRVld=1 with 0xDEADBEEF on the 4th WAIT edge.
  - Required: DRData=0xDEADBEEF, Err=0.
- Spurious MRVld in IDLE and in RESP: no Vld pulse, no state change.
- Reset mid-WAIT: drop rstn while MRRdy=1.
  - Required: MRRdy=0 and Busy=0 without waiting for a clock edge.
  - After release with both requesters high: fetch is granted first.
